// File: rtl/clk_pkg.sv
// Shared clock-rate definitions: board clock, half-period helpers, standard rates
// and the configuration record used by the divider scheduler.
package clk_pkg;

    localparam int unsigned CLK_HZ    = 100_000_000;
    localparam int          PKG_CH_W  = 8;
    localparam int          PKG_CNT_W = 32;

    localparam logic [31:0] HALF_6P25MHZ = 32'd7;
    localparam logic [31:0] HALF_1MHZ    = 32'd49;
    localparam logic [31:0] HALF_1KHZ    = 32'd49_999;

    typedef struct packed {
        logic [PKG_CH_W-1:0]  ch;
        logic [PKG_CNT_W-1:0] half;
        logic                 enable;
    } cfg_t;

    // Output frequency is CLK_HZ / (2*(H+1)), so H = CLK_HZ/(2f) - 1.
    function automatic logic [31:0] hz_to_half(input int unsigned f);
        return 32'(CLK_HZ / (2 * f) - 1);
    endfunction

endpackage

// File: rtl/clock_rate_channel.sv
// One divider channel: half-period counter, 50% duty toggle, tick strobe and
// run state. Rate changes and stops are only honoured at a wrap.
module clock_rate_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] half_in,
    input  logic             stop_req,
    output logic             div_clk,
    output logic             tick,
    output logic             active,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;

    assign wrap = active && (cnt == half);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            half    <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!active) begin
                if (load) begin
                    half    <= half_in;
                    cnt     <= '0;
                    div_clk <= 1'b0;
                    active  <= 1'b1;
                end
            end else if (cnt == half) begin
                cnt     <= '0;
                div_clk <= ~div_clk;
                tick    <= 1'b1;
                if (load) begin
                    half <= half_in;
                end
                // Stopping only from the high phase leaves the channel resting low.
                if (stop_req && div_clk) begin
                    active <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clock_rate_scheduler.sv
// NUM_CH programmable clock dividers with a single-entry valid/ready config port;
// a pending entry is routed to its channel and retired once that channel applies it.
module clock_rate_scheduler
    import clk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              cfg_enable,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ch_clk,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_active,
    output logic              busy
);

    cfg_t              pend;
    logic              pend_vld;
    logic              xfer;
    logic              bad_ch;
    logic [31:0]       ch_ext;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] done;

    assign cfg_ready = ~pend_vld;
    assign busy      = pend_vld;
    assign xfer      = cfg_valid & cfg_ready;
    assign ch_ext    = 32'(cfg_ch);
    assign bad_ch    = (ch_ext >= 32'(NUM_CH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld <= 1'b0;
            pend     <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= xfer && bad_ch;
            if (xfer && !bad_ch) begin
                pend_vld    <= 1'b1;
                pend.ch     <= PKG_CH_W'(cfg_ch);
                pend.half   <= PKG_CNT_W'(cfg_half);
                pend.enable <= cfg_enable;
            end else if (pend_vld && (|done)) begin
                pend_vld <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;

        assign sel = pend_vld && (pend.ch == PKG_CH_W'(i));
        // An idle channel takes (or discards) the entry at once; a running one waits for its wrap.
        assign done[i] = sel && (!ch_active[i] ||
                                 (wrap[i] && (pend.enable || ch_clk[i])));

        clock_rate_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clock    (clock),
            .reset_n  (reset_n),
            .load     (sel && pend.enable),
            .half_in  (CNT_W'(pend.half)),
            .stop_req (sel && !pend.enable),
            .div_clk  (ch_clk[i]),
            .tick     (ch_tick[i]),
            .active   (ch_active[i]),
            .wrap     (wrap[i])
        );
    end

endmodule

// File: tb/tb_clock_rate_scheduler.sv
// Bench for clock_rate_scheduler: event-time reference model of every channel plus
// directed scenarios and a randomized configuration stream.
module tb_clock_rate_scheduler;
    import clk_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 3;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_enable = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_half = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic              busy;
    logic [NUM_CH-1:0] ch_clk;
    logic [NUM_CH-1:0] ch_tick;
    logic [NUM_CH-1:0] ch_active;
    logic [14:0]       obs;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // Reference model: toggle instants kept as absolute edge numbers.
    bit     m_act [NUM_CH];
    bit     m_lvl [NUM_CH];
    bit     m_tick[NUM_CH];
    longint m_half[NUM_CH];
    longint m_next[NUM_CH];
    bit     m_pv, m_pen, m_err;
    int     m_pch;
    longint m_ph;
    longint m_n;

    clock_rate_scheduler #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_half   (cfg_half),
        .cfg_enable (cfg_enable),
        .cfg_err    (cfg_err),
        .ch_clk     (ch_clk),
        .ch_tick    (ch_tick),
        .ch_active  (ch_active),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    assign obs = {cfg_ready, busy, cfg_err, ch_active, ch_tick, ch_clk};

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c] = 0; m_lvl[c] = 0; m_tick[c] = 0; m_half[c] = 0; m_next[c] = 0;
        end
        m_pv = 0; m_pen = 0; m_err = 0; m_pch = 0; m_ph = 0; m_n = 0;
    endfunction

    function automatic void model_edge();
        bit xfer;
        bit done;
        bit wrap;
        bit stop;
        m_n++;
        xfer = cfg_valid && !m_pv;
        done = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            stop = 0;
            wrap = m_act[c] && (m_n == m_next[c]);
            if (m_pv && m_pch == c) begin
                if (!m_act[c]) begin
                    done = 1;
                    if (m_pen) begin
                        m_act[c] = 1; m_lvl[c] = 0; m_half[c] = m_ph; m_next[c] = m_n + m_ph + 1;
                    end
                end else if (wrap && (m_pen || m_lvl[c])) begin
                    done = 1;
                    if (m_pen) m_half[c] = m_ph;
                    else       stop = 1;
                end
            end
            m_tick[c] = wrap;
            if (wrap) begin
                m_lvl[c]  = ~m_lvl[c];
                m_next[c] = m_n + m_half[c] + 1;
                if (stop) m_act[c] = 0;
            end
        end
        m_err = xfer && (int'(cfg_ch) >= NUM_CH);
        if (done) m_pv = 0;
        if (xfer && int'(cfg_ch) < NUM_CH) begin
            m_pv = 1; m_pch = int'(cfg_ch); m_ph = longint'(cfg_half); m_pen = cfg_enable;
        end
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [NUM_CH-1:0] a, t, l;
        for (int c = 0; c < NUM_CH; c++) begin
            a[c] = m_act[c]; t[c] = m_tick[c]; l[c] = m_lvl[c];
        end
        return {~m_pv, m_pv, m_err, a, t, l};
    endfunction

    task automatic tick_clk();
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic drive(input int ch, input longint half, input bit en, input bit v);
        cfg_ch     = CH_W'(ch);
        cfg_half   = CNT_W'(half);
        cfg_enable = en;
        cfg_valid  = v;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (obs !== {1'b1, 14'd0}) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", obs, {1'b1, 14'd0});
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick_clk();
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL idle_after_reset got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_enable_6p25();
        int ticks = 0;
        int rises = 0;
        logic prev;
        do_reset();
        drive(0, longint'(HALF_6P25MHZ), 1, 1);
        tick_clk();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_low_after_xfer got=%b exp=0", cfg_ready);
        end
        tick_clk();
        n_checks++;
        if ({cfg_ready, ch_active[0]} !== 2'b11) begin
            n_fail++; $display("FAIL apply_inactive got=%b exp=11", {cfg_ready, ch_active[0]});
        end
        prev = ch_clk[0];
        repeat (64) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL vec_6p25 cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            if (ch_tick[0]) ticks++;
            if (ch_clk[0] && !prev) rises++;
            prev = ch_clk[0];
        end
        n_checks++;
        if (ticks != 8 || rises != 4) begin
            n_fail++; $display("FAIL rate_6p25 ticks=%0d rises=%0d exp=8/4", ticks, rises);
        end
    endtask

    task automatic test_fast();
        logic prev;
        drive(1, 0, 1, 1);
        tick_clk();
        cfg_valid = 1'b0;
        tick_clk();
        prev = ch_clk[1];
        repeat (10) begin
            tick_clk();
            n_checks++;
            if (ch_tick[1] !== 1'b1 || ch_clk[1] === prev || obs !== exp_vec()) begin
                n_fail++; $display("FAIL fast_toggle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            prev = ch_clk[1];
        end
    endtask

    task automatic test_rate_change();
        longint t0;
        longint tg[3];
        int     nt = 0;
        longint ready_at = -1;
        int     w;
        tg[0] = 0; tg[1] = 0; tg[2] = 0;
        do_reset();
        drive(0, longint'(HALF_6P25MHZ), 1, 1);
        tick_clk();
        cfg_valid = 1'b0;
        tick_clk();
        t0 = cyc;
        w = $urandom_range(0, 6);
        repeat (w) tick_clk();
        drive(0, 3, 1, 1);
        tick_clk();
        drive(2, 2, 1, 1);
        for (int k = 0; k < 30; k++) begin
            tick_clk();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL vec_rate_change cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            if (ready_at >= 0 && cyc == ready_at + 1) cfg_valid = 1'b0;
            if (ch_tick[0] && nt < 3) begin tg[nt] = cyc; nt++; end
            if (cfg_valid && cfg_ready && ready_at < 0) ready_at = cyc;
        end
        n_checks++;
        if (tg[0] - t0 != 8 || tg[1] - tg[0] != 4 || tg[2] - tg[1] != 4) begin
            n_fail++; $display("FAIL rate_change_periods got=%0d,%0d,%0d exp=8,4,4",
                               tg[0] - t0, tg[1] - tg[0], tg[2] - tg[1]);
        end
        n_checks++;
        if (ready_at != tg[0] || ch_active[2] !== 1'b1) begin
            n_fail++; $display("FAIL held_request ready_at=%0d exp=%0d ch2_active=%b", ready_at, tg[0], ch_active[2]);
        end
    endtask

    task automatic test_stop();
        int highs = 0;
        int guard = 0;
        do_reset();
        drive(0, 3, 1, 1);
        tick_clk();
        cfg_valid = 1'b0;
        tick_clk();
        repeat ($urandom_range(1, 10)) tick_clk();
        while (ch_clk[0] && guard < 20) begin tick_clk(); guard++; end
        drive(0, 3, 0, 1);
        tick_clk();
        cfg_valid = 1'b0;
        repeat (30) begin
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL vec_stop cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
            if (ch_clk[0]) highs++;
            tick_clk();
        end
        n_checks++;
        if (highs != 4 || ch_clk[0] !== 1'b0 || ch_active[0] !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_rest highs=%0d exp=4 clk=%b active=%b busy=%b",
                               highs, ch_clk[0], ch_active[0], busy);
        end
    endtask

    task automatic test_bad_ch();
        logic [NUM_CH-1:0] act_before;
        act_before = ch_active;
        drive(5, 2, 1, 1);
        tick_clk();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL bad_ch_err got=%h exp=%h", obs, exp_vec());
        end
        tick_clk();
        n_checks++;
        if (cfg_err !== 1'b0 || ch_active !== act_before) begin
            n_fail++; $display("FAIL bad_ch_after err=%b active=%b exp=0/%b", cfg_err, ch_active, act_before);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (800) begin
            drive($urandom_range(0, 5), $urandom_range(0, 6), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
            tick_clk();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL vec_random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(3, 20, 1, 1);
        tick_clk();
        cfg_valid = 1'b0;
        tick_clk();
        repeat (3) tick_clk();
        drive(3, 20, 0, 1);
        tick_clk();
        cfg_valid = 1'b0;
        repeat (3) tick_clk();
        n_checks++;
        if (busy !== 1'b1 || ch_active[3] !== 1'b1) begin
            n_fail++; $display("FAIL stop_pending busy=%b active=%b exp=1/1", busy, ch_active[3]);
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== {1'b1, 14'd0}) begin
            n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, {1'b1, 14'd0});
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) tick_clk();
        n_checks++;
        if (obs !== exp_vec() || cfg_ready !== 1'b1 || ch_active !== '0) begin
            n_fail++; $display("FAIL after_reset_release got=%h exp=%h", obs, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_enable_6p25();
        test_fast();
        test_rate_change();
        test_stop();
        test_bad_ch();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
